// File: rtl/uart_frame_alu_pkg.sv
// uart_frame_pkg: shared types and helpers for the UART frame ALU.
//   op_e    : 3-bit operation select carried with the first operand byte
//   state_e : frame FSM states
//   nbytes(): number of bytes in one WIDTH-bit operand
package uart_frame_pkg;

   // Operation table (results truncated to WIDTH):
   //   OP_ADD     y = A + B, carry = bit WIDTH of the sum
   //   OP_SUB     y = A - B, carry = borrow (A < B)
   //   OP_PASS_B  y = B
   //   OP_PASS_A  y = A
   //   OP_AND     y = A & B
   //   OP_OR      y = A | B
   //   OP_XOR     y = A ^ B
   //   OP_PASS_A2 y = A (second encoding of pass-A)
   // carry is 0 for every op other than ADD and SUB.
   typedef enum logic [2:0] {
      OP_ADD     = 3'b000,
      OP_SUB     = 3'b001,
      OP_PASS_B  = 3'b010,
      OP_PASS_A  = 3'b011,
      OP_AND     = 3'b100,
      OP_OR      = 3'b101,
      OP_XOR     = 3'b110,
      OP_PASS_A2 = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_COLLECT_A = 2'b00,
      ST_COLLECT_B = 2'b01,
      ST_EXEC      = 2'b10,
      ST_SEND      = 2'b11
   } state_e;

   function automatic int nbytes(input int width);
      return width / 8;
   endfunction

endpackage

// File: rtl/uart_frame_alu_alu.sv
// frame_alu: combinational operation unit for the UART frame ALU.
//   a, b  : WIDTH-bit operands
//   op    : operation select (op_e)
//   y     : WIDTH-bit result, truncated
//   carry : ADD carry-out or SUB borrow, 0 otherwise
module frame_alu
   import uart_frame_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_e              op,
   output logic [WIDTH-1:0] y,
   output logic             carry
);

   logic [WIDTH:0] sum_s;
   logic [WIDTH:0] diff_s;

   // One extra bit on each side exposes carry-out and borrow in the MSB.
   assign sum_s  = {1'b0, a} + {1'b0, b};
   assign diff_s = {1'b0, a} - {1'b0, b};

   // Operation select.
   always_comb begin
      y     = '0;
      carry = 1'b0;
      case (op)
         OP_ADD: begin
            y     = sum_s[WIDTH-1:0];
            carry = sum_s[WIDTH];
         end
         OP_SUB: begin
            y     = diff_s[WIDTH-1:0];
            carry = diff_s[WIDTH];
         end
         OP_PASS_B:  y = b;
         OP_PASS_A:  y = a;
         OP_AND:     y = a & b;
         OP_OR:      y = a | b;
         OP_XOR:     y = a ^ b;
         OP_PASS_A2: y = a;
         default: begin
            y     = a;
            carry = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/uart_frame_alu.sv
// uart_frame_alu: assembles two little-endian WIDTH-bit operands from a UART
// byte stream, applies one of eight operations, holds the result for display
// and streams the result bytes (LSB first) over a valid/ready handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   rx_valid, rx_data   : received-byte strobe and data
//   op                  : operation, sampled with the first byte of A
//   tx_ready            : transmitter can accept a byte
//   tx_valid, tx_data   : outgoing result byte
//   result, carry       : last computed result / carry, held
//   result_valid        : one-cycle pulse when result updates
//   busy                : low only when idle in COLLECT_A with no bytes
//   frame_err           : one-cycle pulse on inter-byte timeout
//   overrun             : one-cycle pulse when a byte is dropped in EXEC/SEND
module uart_frame_alu
   import uart_frame_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int TIMEOUT_CYCLES = 500000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   input  logic [2:0]       op,
   input  logic             tx_ready,
   output logic             tx_valid,
   output logic [7:0]       tx_data,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             carry,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun
);

   localparam int NB = nbytes(WIDTH);
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_e            state_r;
   state_e            state_nx_s;
   logic [CW-1:0]     cnt_r;
   logic [CW-1:0]     cnt_nx_s;
   logic [TW-1:0]     tmo_r;
   logic              take_s;
   logic              tmo_run_s;
   logic              tmo_fire_s;
   logic [WIDTH-1:0]  a_r;
   logic [WIDTH-1:0]  b_r;
   op_e               op_r;
   logic              launch_r;
   logic [CW-1:0]     tx_idx_r;
   logic [CW-1:0]     tx_idx_nx_s;
   logic [7:0]        tx_byte_s;
   logic [WIDTH-1:0]  alu_y_s;
   logic              alu_c_s;
   logic [WIDTH-1:0]  result_r;
   logic              carry_r;
   logic              result_valid_r;
   logic              tx_valid_r;
   logic [7:0]        tx_data_r;
   logic              busy_r;
   logic              frame_err_r;
   logic              overrun_r;

   frame_alu #(.WIDTH(WIDTH)) u_alu (
      .a     (a_r),
      .b     (b_r),
      .op    (op_r),
      .y     (alu_y_s),
      .carry (alu_c_s)
   );

   assign tx_idx_nx_s = tx_idx_r + 1'b1;
   assign tx_byte_s   = 8'(result_r >> {tx_idx_nx_s, 3'b000});

   // Next-state, byte-count and timeout decisions.
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      take_s     = 1'b0;
      tmo_run_s  = 1'b0;
      tmo_fire_s = 1'b0;
      case (state_r)
         ST_COLLECT_A, ST_COLLECT_B: begin
            if (rx_valid) begin
               // A byte in the timeout cycle wins: it is taken, no error.
               take_s = 1'b1;
               if (cnt_r == LAST_IDX) begin
                  state_nx_s = (state_r == ST_COLLECT_A) ? ST_COLLECT_B : ST_EXEC;
                  cnt_nx_s   = '0;
               end else begin
                  cnt_nx_s = cnt_r + 1'b1;
               end
            end else if ((state_r == ST_COLLECT_B) || (cnt_r != '0)) begin
               tmo_run_s = 1'b1;
               if (tmo_r == TMO_LAST) begin
                  tmo_fire_s = 1'b1;
                  state_nx_s = ST_COLLECT_A;
                  cnt_nx_s   = '0;
               end else begin
                  cnt_nx_s = cnt_r;
               end
            end else begin
               cnt_nx_s = cnt_r;
            end
         end
         ST_EXEC: begin
            state_nx_s = ST_SEND;
         end
         ST_SEND: begin
            if (tx_valid_r && tx_ready && (tx_idx_r == LAST_IDX)) begin
               state_nx_s = ST_COLLECT_A;
            end else begin
               state_nx_s = ST_SEND;
            end
         end
         default: begin
            state_nx_s = ST_COLLECT_A;
            cnt_nx_s   = '0;
         end
      endcase
   end

   // FSM state and receive byte count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_COLLECT_A;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
      end
   end

   // Operand byte capture, op latch and inter-byte timeout counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= '0;
         b_r   <= '0;
         op_r  <= OP_ADD;
         tmo_r <= '0;
      end else begin
         if (take_s) begin
            if (state_r == ST_COLLECT_A) begin
               a_r[{cnt_r, 3'b000} +: 8] <= rx_data;
               if (cnt_r == '0) begin
                  op_r <= op_e'(op);
               end
            end else begin
               b_r[{cnt_r, 3'b000} +: 8] <= rx_data;
            end
         end
         if (tmo_run_s && !tmo_fire_s) begin
            tmo_r <= tmo_r + 1'b1;
         end else begin
            tmo_r <= '0;
         end
      end
   end

   // Result capture and TX byte streaming. The operands are frozen outside
   // the collect states, so the ALU output is captured on the edge after
   // EXEC, together with the first TX byte and the result_valid pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         launch_r       <= 1'b0;
         result_r       <= '0;
         carry_r        <= 1'b0;
         result_valid_r <= 1'b0;
         tx_valid_r     <= 1'b0;
         tx_data_r      <= 8'h00;
         tx_idx_r       <= '0;
      end else begin
         launch_r       <= (state_r == ST_EXEC);
         result_valid_r <= 1'b0;
         if (launch_r) begin
            result_r       <= alu_y_s;
            carry_r        <= alu_c_s;
            result_valid_r <= 1'b1;
            tx_valid_r     <= 1'b1;
            tx_data_r      <= alu_y_s[7:0];
            tx_idx_r       <= '0;
         end else if (tx_valid_r && tx_ready) begin
            if (tx_idx_r == LAST_IDX) begin
               tx_valid_r <= 1'b0;
               tx_idx_r   <= '0;
            end else begin
               tx_idx_r  <= tx_idx_nx_s;
               tx_data_r <= tx_byte_s;
            end
         end
      end
   end

   // Status flags: busy follows the next state, error pulses last one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r      <= 1'b0;
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;
      end else begin
         busy_r      <= !((state_nx_s == ST_COLLECT_A) && (cnt_nx_s == '0));
         frame_err_r <= tmo_fire_s;
         overrun_r   <= rx_valid && ((state_r == ST_EXEC) || (state_r == ST_SEND));
      end
   end

   assign tx_valid     = tx_valid_r;
   assign tx_data      = tx_data_r;
   assign result       = result_r;
   assign result_valid = result_valid_r;
   assign carry        = carry_r;
   assign busy         = busy_r;
   assign frame_err    = frame_err_r;
   assign overrun      = overrun_r;

endmodule

// File: tb/tb_uart_frame_alu.sv
// Self-checking bench for uart_frame_alu (WIDTH=32, TIMEOUT_CYCLES=16).
module tb_uart_frame_alu;

   localparam int W   = 32;
   localparam int NB  = 4;
   localparam int TMO = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         rx_valid;
   logic [7:0]   rx_data;
   logic [2:0]   op;
   logic         tx_ready;
   logic         tx_valid;
   logic [7:0]   tx_data;
   logic [W-1:0] result;
   logic         result_valid;
   logic         carry;
   logic         busy;
   logic         frame_err;
   logic         overrun;

   int checks = 0;
   int errors = 0;

   logic [7:0] tx_q[$];
   int rv_cnt = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;

   uart_frame_alu #(.WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .op           (op),
      .tx_ready     (tx_ready),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .result       (result),
      .result_valid (result_valid),
      .carry        (carry),
      .busy         (busy),
      .frame_err    (frame_err),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   // Observe handshakes and pulses mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      if (result_valid) rv_cnt++;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: {carry, result} from the operation table.
   function automatic logic [W:0] ref_alu(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] r;
      case (o)
         3'd0:    r = {1'b0, a} + {1'b0, b};
         3'd1:    r = {(a < b) ? 1'b1 : 1'b0, a - b};
         3'd2:    r = {1'b0, b};
         3'd4:    r = {1'b0, a & b};
         3'd5:    r = {1'b0, a | b};
         3'd6:    r = {1'b0, a ^ b};
         default: r = {1'b0, a};
      endcase
      return r;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic rx_byte(input logic [7:0] d, input logic [2:0] o);
      rx_valid = 1'b1;
      rx_data  = d;
      op       = o;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic load_bytes(input logic [2:0] o_first, input logic [2:0] o_rest,
                             input logic [W-1:0] a, input logic [W-1:0] b, input int gap_max);
      for (int i = 0; i < 2 * NB; i++) begin
         rx_byte((i < NB) ? a[8*i +: 8] : b[8*(i-NB) +: 8], (i == 0) ? o_first : o_rest);
         if ((i < 2 * NB - 1) && (gap_max > 0)) idle($urandom_range(gap_max, 0));
      end
   endtask

   task automatic drain(input bit rand_ready, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         tx_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
         idle(1);
         if ((tx_q.size() == NB) && !tx_valid) begin
            ok = 1'b1;
            break;
         end
      end
      tx_ready = 1'b1;
   endtask

   // Full frame: load, optional latency check, drain, check everything.
   task automatic run_frame(input string name, input logic [2:0] o_first, input logic [2:0] o_rest,
                            input logic [W-1:0] a, input logic [W-1:0] b,
                            input int gap_max, input bit rand_ready, input bit lat_check);
      logic [W:0] exp;
      bit ok;
      exp = ref_alu(o_first, a, b);
      tx_q.delete();
      rv_cnt   = 0;
      tx_ready = 1'b1;
      load_bytes(o_first, o_rest, a, b, gap_max);
      if (lat_check) begin
         checks++;
         if ({result_valid, tx_valid} !== 2'b00) begin
            errors++;
            $display("FAIL %s lat_k0: rv/txv=%b want 00", name, {result_valid, tx_valid});
         end
         idle(1);
         checks++;
         if ({result_valid, tx_valid} !== 2'b00) begin
            errors++;
            $display("FAIL %s lat_k1: rv/txv=%b want 00", name, {result_valid, tx_valid});
         end
         idle(1);
         checks++;
         if ({result_valid, tx_valid, tx_data, result} !== {2'b11, exp[7:0], exp[W-1:0]}) begin
            errors++;
            $display("FAIL %s lat_k2: rv=%b txv=%b txd=%h res=%h want 1 1 %h %h",
                     name, result_valid, tx_valid, tx_data, result, exp[7:0], exp[W-1:0]);
         end
      end
      drain(rand_ready, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s drain: got %0d bytes txv=%b want %0d bytes and txv=0", name, tx_q.size(), tx_valid, NB);
      end
      checks++;
      if (result !== exp[W-1:0]) begin
         errors++;
         $display("FAIL %s result: got %h want %h", name, result, exp[W-1:0]);
      end
      checks++;
      if (carry !== exp[W]) begin
         errors++;
         $display("FAIL %s carry: got %b want %b", name, carry, exp[W]);
      end
      checks++;
      if (rv_cnt !== 1) begin
         errors++;
         $display("FAIL %s rv_pulses: got %0d want 1", name, rv_cnt);
      end
      for (int i = 0; i < NB; i++) begin
         logic [7:0] got;
         logic [W-1:0] sh;
         got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
         sh  = exp[W-1:0] >> (8 * i);
         checks++;
         if (got !== sh[7:0]) begin
            errors++;
            $display("FAIL %s tx_byte%0d: got %h want %h", name, i, got, sh[7:0]);
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_end: got %b want 0", name, busy);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; op = 3'd0; tx_ready = 1'b1;
      idle(3);
      checks++;
      if ({tx_valid, tx_data, result, result_valid, carry, busy, frame_err, overrun} !== '0) begin
         errors++;
         $display("FAIL reset_state: txv=%b txd=%h res=%h rv=%b c=%b busy=%b fe=%b ov=%b want all 0",
                  tx_valid, tx_data, result, result_valid, carry, busy, frame_err, overrun);
      end
      rst_n = 1'b1;
      idle(2);
      checks++;
      if ({tx_valid, result, busy} !== '0) begin
         errors++;
         $display("FAIL reset_release: txv=%b res=%h busy=%b want 0", tx_valid, result, busy);
      end
   endtask

   task automatic test_add;
      run_frame("add", 3'd0, 3'd0, 32'h12345678, 32'h11111111, 0, 1'b0, 1'b1);
      checks++;
      if (result !== 32'h23456789) begin
         errors++;
         $display("FAIL add_const: got %h want 23456789", result);
      end
   endtask

   task automatic test_sub;
      run_frame("sub", 3'd1, 3'd1, 32'h00000001, 32'h00000002, 0, 1'b0, 1'b1);
      checks++;
      if ({carry, result} !== {1'b1, 32'hFFFFFFFF}) begin
         errors++;
         $display("FAIL sub_const: got %b %h want 1 ffffffff", carry, result);
      end
   endtask

   task automatic test_timeout;
      fe_cnt = 0;
      rx_byte(8'hAA, 3'd0);
      rx_byte(8'hBB, 3'd0);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL tmo_busy: got %b want 1", busy);
      end
      idle(TMO - 1);
      checks++;
      if ((frame_err !== 1'b0) || (fe_cnt != 0)) begin
         errors++;
         $display("FAIL tmo_early: fe=%b pulses=%0d want 0", frame_err, fe_cnt);
      end
      idle(1);
      checks++;
      if (frame_err !== 1'b1) begin
         errors++;
         $display("FAIL tmo_fire: fe=%b want 1", frame_err);
      end
      idle(1);
      checks++;
      if ({frame_err, busy} !== 2'b00 || fe_cnt != 1) begin
         errors++;
         $display("FAIL tmo_after: fe=%b busy=%b pulses=%0d want 0 0 1", frame_err, busy, fe_cnt);
      end
      run_frame("tmo_next", 3'd0, 3'd0, 32'h00000001, 32'h00000002, 0, 1'b0, 1'b0);
      checks++;
      if (fe_cnt != 1) begin
         errors++;
         $display("FAIL tmo_no_more: pulses=%0d want 1", fe_cnt);
      end
   endtask

   task automatic test_backpressure;
      logic [W-1:0] a, b;
      logic [W:0] exp;
      bit ok;
      int n;
      a = $urandom; b = $urandom;
      exp = ref_alu(3'd6, a, b);
      tx_q.delete(); ov_cnt = 0;
      tx_ready = 1'b0;
      load_bytes(3'd6, 3'd6, a, b, 0);
      n = 0;
      while (!tx_valid && n < 20) begin
         idle(1);
         n++;
      end
      for (int c = 0; c < 50; c++) begin
         if (c == 10) rx_byte(8'h55, 3'd2);
         else idle(1);
         checks++;
         if ({tx_valid, tx_data} !== {1'b1, exp[7:0]}) begin
            errors++;
            $display("FAIL bp_hold%0d: txv=%b txd=%h want 1 %h", c, tx_valid, tx_data, exp[7:0]);
         end
         if (c == 10) begin
            checks++;
            if (overrun !== 1'b1) begin
               errors++;
               $display("FAIL bp_overrun: got %b want 1", overrun);
            end
         end
         if (c == 11) begin
            checks++;
            if (overrun !== 1'b0) begin
               errors++;
               $display("FAIL bp_overrun_end: got %b want 0", overrun);
            end
         end
      end
      drain(1'b0, ok);
      checks++;
      if (!ok || ov_cnt != 1 || result !== exp[W-1:0]) begin
         errors++;
         $display("FAIL bp_finish: ok=%b ov_pulses=%0d res=%h want 1 1 %h", ok, ov_cnt, result, exp[W-1:0]);
      end
      for (int i = 0; i < NB; i++) begin
         logic [W-1:0] sh;
         logic [7:0] got;
         sh  = exp[W-1:0] >> (8 * i);
         got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
         checks++;
         if (got !== sh[7:0]) begin
            errors++;
            $display("FAIL bp_tx%0d: got %h want %h", i, got, sh[7:0]);
         end
      end
      run_frame("bp_next", 3'd0, 3'd0, $urandom, $urandom, 1, 1'b0, 1'b0);
   endtask

   task automatic test_op_change;
      run_frame("opchg", 3'd2, 3'd0, 32'h0000000F, 32'h000000F0, 0, 1'b0, 1'b0);
      checks++;
      if ({carry, result} !== {1'b0, 32'h000000F0}) begin
         errors++;
         $display("FAIL opchg_const: got %b %h want 0 000000f0", carry, result);
      end
   endtask

   task automatic test_reset_mid_send;
      int n;
      tx_q.delete();
      tx_ready = 1'b1;
      load_bytes(3'd0, 3'd0, 32'hF0F0F0F0, 32'h1F1F1F1F, 0);
      n = 0;
      while (tx_q.size() < 2 && n < 50) begin
         idle(1);
         n++;
      end
      checks++;
      if ({tx_valid, busy} !== 2'b11) begin
         errors++;
         $display("FAIL rst_pre: txv=%b busy=%b want 1 1", tx_valid, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({tx_valid, result, carry, busy} !== '0) begin
         errors++;
         $display("FAIL rst_async: txv=%b res=%h c=%b busy=%b want 0", tx_valid, result, carry, busy);
      end
      @(posedge clk); #1;
      idle(1);
      rst_n = 1'b1;
      idle(1);
      run_frame("rst_fresh", 3'd1, 3'd1, 32'h00001000, 32'h00000001, 0, 1'b0, 1'b0);
   endtask

   task automatic test_random;
      for (int t = 0; t < 24; t++) begin
         logic [2:0] o;
         o = 3'($urandom_range(7, 0));
         run_frame("rand", o, 3'($urandom_range(7, 0)), $urandom, $urandom, 3, 1'b1, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_timeout();
      test_backpressure();
      test_op_change();
      test_reset_mid_send();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_frame_alu.md
Name: uart_frame_alu

Overview:
Parametrised successor to the fixed 32-bit receive/add/display path. Consumes the UART receiver's byte stream and assembles two WIDTH-bit operands, little-endian. Executes one of eight operations and holds the result for the seven-segment display. Streams the result bytes to the UART transmitter over a valid/ready handshake, with inter-byte timeout and overrun detection.

Parameters:
WIDTH, 32, operand/result width in bits; multiple of 8, range 8..64
TIMEOUT_CYCLES, 500000, max clk cycles between accepted bytes of one frame (10 ms at 50 MHz); must be >= 2

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  reset, asynchronous assert, active-low
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
op  in  3  operation select; sampled when the first byte of a frame is accepted
tx_ready  in  1  transmitter can accept a byte (i.e. not Tx_busy)
tx_valid  out  1  tx_data holds a result byte to send
tx_data  out  8  result byte
result  out  WIDTH  last computed result, held for display
result_valid  out  1  one-cycle pulse when result updates
carry  out  1  ADD carry-out / SUB borrow; 0 for other ops
busy  out  1  high in every state except COLLECT_A with byte count 0
frame_err  out  1  one-cycle pulse on inter-byte timeout
overrun  out  1  one-cycle pulse when a byte arrives in EXEC or SEND and is dropped

Behaviour:
- Reset (rst_n=0, async): state COLLECT_A, byte count 0, timeout counter 0. All outputs 0, including result and carry.
- NB = WIDTH/8. Byte i of an operand fills bits [8i+7:8i]; byte 0 is received first.
- States: COLLECT_A, COLLECT_B, EXEC, SEND.
- COLLECT_A: each rx_valid stores a byte into A. The first byte also latches op. After byte NB-1, go to COLLECT_B with count 0.
- COLLECT_B: each rx_valid stores a byte into B. After byte NB-1, go to EXEC.
- Timeout: the counter clears on every accepted byte. It increments while in COLLECT_A with count>0, or in COLLECT_B. On reaching TIMEOUT_CYCLES with no byte: pulse frame_err, go to COLLECT_A, count 0, partial operands discarded. A byte arriving in the same cycle as the timeout is accepted and the counter clears; no timeout fires.
- EXEC (exactly one cycle): result <= f(A,B) and carry registered. Next cycle: result_valid=1 for one cycle, state SEND, tx_valid=1, tx_data=result[7:0].
- Latency: last B byte accepted at edge k, result/result_valid/tx_valid visible after edge k+2.
- Op encoding: 000 ADD (A+B, carry = bit WIDTH). 001 SUB (A-B, carry = borrow). 010 PASS_B. 011 PASS_A. 100 AND. 101 OR. 110 XOR. 111 PASS_A. Results are truncated to WIDTH.
- SEND: a byte transfers on any edge with tx_valid && tx_ready. tx_data advances to the next byte. tx_valid and tx_data hold stable while tx_ready=0. After byte NB-1 transfers: tx_valid=0, state COLLECT_A. result and carry keep their values until the next EXEC.
- rx_valid in EXEC or SEND: byte dropped, overrun pulses in the same cycle as the registered response (next edge). The state machine is unaffected.
- A change on op mid-frame is ignored.
- rst_n asserted mid-frame or mid-SEND: immediate return to reset values. A partially sent result is not resumed.

Decomposition:
- Package uart_frame_pkg: op_e enum (OP_ADD..OP_PASS_A2, 3 bits), state_e enum, the op-to-function table comments, helper function for the byte count (NB).
- Sub-module frame_alu: combinational, parameter WIDTH; in a, b, op; out y[WIDTH-1:0], carry. Instantiated once.
- Top holds the FSM, operand shift/byte registers, timeout counter and TX byte index.

Test Plan:
1. WIDTH=32, op=000. RX 78 56 34 12 then 11 11 11 11 -> result=0x23456789, carry=0, result_valid single pulse. tx_ready=1: TX bytes 89 67 45 23, then tx_valid=0, busy=0.
2. op=001. A=0x00000001, B=0x00000002 -> result=0xFFFFFFFF, carry=1. TX FF FF FF FF.
3. TIMEOUT_CYCLES=16. RX AA BB, then 16 idle cycles -> frame_err pulses once. The next 8 bytes 01 00 00 00 02 00 00 00 with op=000 give result=0x00000003.
4. During SEND hold tx_ready=0 for 50 cycles -> tx_valid=1 and tx_data constant. Inject rx_valid with byte 55 -> overrun pulse; the frame that follows is unaffected.
5. Change op from 010 to 000 after byte 0 of A. A=0x0000000F, B=0x000000F0 -> result=0x000000F0 (PASS_B retained), carry=0.
6. Assert rst_n=0 after the second TX byte -> tx_valid, result, carry, busy all 0 asynchronously. After release, a fresh frame computes correctly.
